fpu_iter_arbiter: RTL and testbench
===================================

// Module: fpu_iter_arbiter
// PURPOSE
//  Shares one iterative FP unit (Newton sqrt/div core, fixed multi-cycle latency, own busy/stall)
//  between NREQ requesters. Round-robin grant, latches operands, sequences the unit's start pulse,
//  times the iteration, captures the result and returns it with the requester id under
//  valid/ready back-pressure. Sits between the pipeline's FP issue ports and the iterative core.
// PARAMETERS
//  NREQ  2   number of requesters (2..4); id width IDW = 2
//  LAT   22  cycles from u_start to u_result valid (core count 1..0x16)
// PORTS
//  clk        in   1         clock; all state updates on posedge
//  rst        in   1         synchronous reset, active-high
//  req_valid  in   NREQ      request pending, one bit per requester
//  req_op     in   NREQ      0 = sqrt (a only), 1 = div (a/b)
//  req_a      in   32*NREQ   operand a, requester i in [32i+31:32i]
//  req_b      in   32*NREQ   operand b (ignored for sqrt)
//  req_rm     in   2*NREQ    rounding mode
//  req_ready  out  NREQ      one-hot accept; request i taken when req_valid[i] & req_ready[i]
//  flush      in   1         cancel in-flight/held op, no response returned
//  u_start    out  1         one-cycle start pulse to core
//  u_op       out  1         latched op
//  u_a, u_b   out  32        latched operands
//  u_rm       out  2         latched rounding mode
//  u_busy     in   1         core busy
//  u_result   in   32        core result, valid LAT cycles after u_start
//  rsp_valid  out  1         response valid
//  rsp_id     out  2         requester id of response
//  rsp_data   out  32        result
//  rsp_ready  in   1         response consumer ready
//  err        out  1         sticky: core still busy at capture cycle
// BEHAVIOUR
//  Reset: state IDLE, rr pointer 0, counter 0, all outputs 0 (req_ready, u_*, rsp_*, err).
//  FSM IDLE->ISSUE->WAIT->HOLD->IDLE.
//  IDLE: req_ready = one-hot of first valid requester at/after rr pointer (round robin), else 0.
//   Combinational from req_valid; at most one bit set. On accept (cycle T): latch op/a/b/rm/id,
//   rr pointer <= id+1 mod NREQ, go ISSUE. req_ready = 0 in all other states.
//  ISSUE: if u_busy, hold (no pulse). Else u_start=1 for exactly this cycle, counter<=LAT, go WAIT.
//   No-busy case: u_start high in cycle T+1.
//  WAIT: counter decrements each cycle; at counter==1 capture u_result into rsp_data; if u_busy
//   is high then, set err. Go HOLD. Capture occurs in cycle T+1+LAT; rsp_valid high from T+2+LAT.
//  HOLD: rsp_valid=1, rsp_id/rsp_data stable until rsp_ready; on rsp_valid&rsp_ready go IDLE.
//   A new request can be accepted no earlier than the cycle after the handshake.
//  u_op/u_a/u_b/u_rm stable from ISSUE through end of WAIT.
//  flush: IDLE/ISSUE -> IDLE immediately, no u_start. WAIT -> set drop flag, keep counting (core
//   cannot be aborted), at capture go IDLE with no rsp_valid. HOLD -> drop rsp, IDLE next cycle.
//   flush has priority over accept and over rsp handshake in the same cycle.
//  rst mid-operation: returns to reset state next edge; core is reset by same domain.
//  err cleared only by rst.
// TESTING
//  1 req0 sqrt a=0x40800000 (4.0), core model LAT=22 -> u_start at T+1, rsp at T+24,
//    rsp_id=0, rsp_data=0x40000000.
//  2 req0, req1 valid together, rr=0 -> req0 served first, then req1 (div 0x40C00000/0x40000000
//    -> 0x40400000); rr pointer ends at 0.
//  3 rsp_ready low 10 cycles in HOLD -> rsp_valid/rsp_data stable, req_ready stays 0.
//  4 flush at WAIT count 10 -> no rsp_valid, state IDLE at T+1+LAT+1, next request accepted.
//  5 u_busy held high 3 cycles at ISSUE -> u_start delayed 3 cycles, single pulse; busy high at
//    capture -> err=1 and stays until rst.
//  6 rst asserted in WAIT -> next cycle all outputs 0, state IDLE, rr pointer 0.

Source files
------------

// File: rtl/fpu_iter_arbiter.sv
// Round-robin front end for one shared iterative FP core (sqrt/div).
// Grants one requester, latches its operands, starts the core, times its latency, returns the result.
module fpu_iter_arbiter #(
  parameter int NREQ = 2,
  parameter int LAT  = 22
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ-1:0]      req_op,
  input  logic [32*NREQ-1:0]   req_a,
  input  logic [32*NREQ-1:0]   req_b,
  input  logic [2*NREQ-1:0]    req_rm,
  output logic [NREQ-1:0]      req_ready,
  input  logic                 flush,
  output logic                 u_start,
  output logic                 u_op,
  output logic [31:0]          u_a,
  output logic [31:0]          u_b,
  output logic [1:0]           u_rm,
  input  logic                 u_busy,
  input  logic [31:0]          u_result,
  output logic                 rsp_valid,
  output logic [1:0]           rsp_id,
  output logic [31:0]          rsp_data,
  input  logic                 rsp_ready,
  output logic                 err
);
  localparam int IDW = 2;
  localparam int CW  = $clog2(LAT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_HOLD} state_t;

  state_t          r_state;
  logic [IDW-1:0]  r_rr, r_id;
  logic [CW-1:0]   r_cnt;
  logic            r_drop;
  logic            r_op, r_rsp_valid, r_err;
  logic [31:0]     r_a, r_b, r_rsp_data;
  logic [1:0]      r_rm, r_rsp_id;

  logic            w_any, w_accept;
  logic [IDW-1:0]  w_gid;
  logic [NREQ-1:0] w_gnt;

  // First valid requester at or after the rr pointer; flush suppresses the grant entirely.
  always_comb begin
    w_any = 1'b0;
    w_gid = '0;
    w_gnt = '0;
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = (int'(r_rr) + k) % NREQ;
      if (!w_any && req_valid[j]) begin
        w_any = 1'b1;
        w_gid = IDW'(j);
        if (r_state == S_IDLE && !flush) w_gnt[j] = 1'b1;
      end
    end
  end

  assign w_accept  = |(req_valid & w_gnt);
  assign req_ready = w_gnt;
  assign u_start   = (r_state == S_ISSUE) && !u_busy && !flush;
  assign u_op      = r_op;
  assign u_a       = r_a;
  assign u_b       = r_b;
  assign u_rm      = r_rm;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_data  = r_rsp_data;
  assign err       = r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_rr        <= '0;
      r_id        <= '0;
      r_cnt       <= '0;
      r_drop      <= 1'b0;
      r_op        <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_rm        <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_data  <= '0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_op    <= req_op[w_gid];
          r_a     <= req_a[32*int'(w_gid) +: 32];
          r_b     <= req_b[32*int'(w_gid) +: 32];
          r_rm    <= req_rm[2*int'(w_gid) +: 2];
          r_id    <= w_gid;
          r_rr    <= (w_gid == IDW'(NREQ-1)) ? '0 : w_gid + 1'b1;
          r_drop  <= 1'b0;
          r_state <= S_ISSUE;
        end
        S_ISSUE: begin
          if (flush) r_state <= S_IDLE;
          else if (!u_busy) begin
            r_cnt   <= CW'(LAT);
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          // The core cannot be aborted, so a flush only marks the result for discard.
          r_cnt <= r_cnt - 1'b1;
          if (flush) r_drop <= 1'b1;
          if (r_cnt == CW'(1)) begin
            if (u_busy) r_err <= 1'b1;
            if (r_drop || flush) r_state <= S_IDLE;
            else begin
              r_rsp_data  <= u_result;
              r_rsp_id    <= r_id;
              r_rsp_valid <= 1'b1;
              r_state     <= S_HOLD;
            end
          end
        end
        S_HOLD: if (flush || rsp_ready) begin
          r_rsp_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fpu_iter_arbiter.sv
// Directed bench for fpu_iter_arbiter with a fixed-latency core model driving u_result.
module tb_fpu_iter_arbiter;
  localparam int NREQ = 2;
  localparam int LAT  = 22;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid, req_op, req_ready;
  logic [32*NREQ-1:0] req_a, req_b;
  logic [2*NREQ-1:0] req_rm;
  logic              flush, u_start, u_op, u_busy;
  logic [31:0]       u_a, u_b, u_result, rsp_data;
  logic [1:0]        u_rm, rsp_id;
  logic              rsp_valid, rsp_ready, err;

  int n_chk = 0;
  int n_fail = 0;

  fpu_iter_arbiter #(.NREQ(NREQ), .LAT(LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op), .req_a(req_a),
    .req_b(req_b), .req_rm(req_rm), .req_ready(req_ready), .flush(flush),
    .u_start(u_start), .u_op(u_op), .u_a(u_a), .u_b(u_b), .u_rm(u_rm),
    .u_busy(u_busy), .u_result(u_result), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_ready(rsp_ready), .err(err)
  );

  always #5 clk = ~clk;

  // Core model: result valid exactly LAT cycles after the start pulse, garbage otherwise.
  logic        m_op = 1'b0;
  logic [31:0] m_a = '0, m_b = '0;
  int          m_cnt = -1;
  always @(posedge clk) begin
    if (u_start) begin
      m_op <= u_op; m_a <= u_a; m_b <= u_b; m_cnt <= LAT - 1;
    end else if (m_cnt >= 0) m_cnt <= m_cnt - 1;
  end

  function automatic logic [31:0] core_fn(input logic op, input logic [31:0] a, input logic [31:0] b);
    if (!op && a == 32'h40800000) return 32'h40000000;
    if (op && a == 32'h40C00000 && b == 32'h40000000) return 32'h40400000;
    return 32'h7FC00000;
  endfunction

  assign u_result = (m_cnt == 0) ? core_fn(m_op, m_a, m_b) : 32'hDEADBEEF;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic op, input logic [31:0] a, input logic [31:0] b);
    req_op[i]          = op;
    req_a[32*i +: 32]  = a;
    req_b[32*i +: 32]  = b;
    req_rm[2*i +: 2]   = 2'(i + 1);
    req_valid[i]       = 1'b1;
  endtask

  // Waits (bounded) for a response, checks it, optionally stalls in HOLD, then handshakes.
  task automatic serve(input string tag, input logic [1:0] eid, input logic [31:0] edata, input int hold);
    int n = 0;
    logic bad = 1'b0;
    while (!rsp_valid && n < 60) begin tick(); n++; end
    chk({tag, "_rsp_valid"}, rsp_valid, 1);
    chk({tag, "_rsp_id"}, rsp_id, eid);
    chk({tag, "_rsp_data"}, rsp_data, edata);
    rsp_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      tick();
      if (rsp_valid !== 1'b1 || rsp_data !== edata || rsp_id !== eid || req_ready !== '0) bad = 1'b1;
    end
    if (hold > 0) chk({tag, "_hold_stable"}, bad, 0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk({tag, "_rsp_done"}, rsp_valid, 0);
  endtask

  initial begin
    logic bad;
    rst = 1'b1; req_valid = '0; req_op = '0; req_a = '0; req_b = '0; req_rm = '0;
    flush = 1'b0; u_busy = 1'b0; rsp_ready = 1'b0;
    tick(); tick();
    chk("rst_req_ready", req_ready, 0);
    chk("rst_u_start", u_start, 0);
    chk("rst_u_ops", {u_op, u_rm, u_a[28:0]} | u_b, 0);
    chk("rst_rsp", {rsp_valid, rsp_id, rsp_data[28:0]}, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;
    tick();

    // 1: single sqrt, exact latency
    set_req(0, 1'b0, 32'h40800000, 32'h0);
    #1 chk("t1_req_ready", req_ready, 2'b01);
    tick();
    req_valid = '0;
    chk("t1_u_start", u_start, 1);
    chk("t1_u_a", u_a, 32'h40800000);
    chk("t1_u_rm", u_rm, 2'd1);
    bad = 1'b0;
    for (int i = 0; i < LAT; i++) begin
      tick();
      if (u_start || rsp_valid || u_a !== 32'h40800000) bad = 1'b1;
    end
    chk("t1_wait_quiet", bad, 0);
    tick();
    chk("t1_rsp_at_T24", rsp_valid, 1);
    serve("t1", 2'd0, 32'h40000000, 0);

    // 2: round robin from rr=0
    rst = 1'b1; tick(); rst = 1'b0;
    set_req(0, 1'b0, 32'h40800000, 32'h0);
    set_req(1, 1'b1, 32'h40C00000, 32'h40000000);
    #1 chk("t2_grant0", req_ready, 2'b01);
    tick();
    req_valid[0] = 1'b0;
    chk("t2_busy_no_grant", req_ready, 0);
    serve("t2a", 2'd0, 32'h40000000, 0);
    chk("t2_grant1", req_ready, 2'b10);
    tick();
    req_valid = '0;
    serve("t2b", 2'd1, 32'h40400000, 0);
    req_valid = 2'b11;
    #1 chk("t2_rr_back_to_0", req_ready, 2'b01);
    req_valid = '0;
    #1;

    // 3: back-pressure in HOLD with another requester waiting
    set_req(0, 1'b0, 32'h40800000, 32'h0);
    tick();
    req_valid = 2'b10;
    serve("t3", 2'd0, 32'h40000000, 10);
    req_valid = '0;
    tick();

    // 4: flush at count 10 drops the response
    set_req(0, 1'b0, 32'h40800000, 32'h0);
    tick();
    req_valid = '0;
    for (int i = 0; i < 13; i++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (rsp_valid) bad = 1'b1;
    end
    set_req(0, 1'b0, 32'h40800000, 32'h0);
    #1 chk("t4_still_wait", req_ready, 0);
    tick();
    chk("t4_no_rsp", bad | rsp_valid, 0);
    chk("t4_idle_accept", req_ready, 2'b01);
    tick();
    req_valid = '0;
    serve("t4", 2'd0, 32'h40000000, 0);

    // 5: busy stalls the start pulse; busy at capture raises sticky err
    set_req(0, 1'b0, 32'h40800000, 32'h0);
    tick();
    req_valid = '0;
    u_busy = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 if (u_start) bad = 1'b1;
      tick();
    end
    u_busy = 1'b0;
    #1 chk("t5_no_early_start", bad, 0);
    chk("t5_start_delayed", u_start, 1);
    bad = 1'b0;
    for (int i = 0; i < LAT - 1; i++) begin
      tick();
      if (u_start || rsp_valid) bad = 1'b1;
    end
    chk("t5_single_pulse", bad, 0);
    tick();
    u_busy = 1'b1;
    chk("t5_err_before", err, 0);
    tick();
    u_busy = 1'b0;
    chk("t5_err_set", err, 1);
    serve("t5", 2'd0, 32'h40000000, 0);
    tick(); tick();
    chk("t5_err_sticky", err, 1);

    // 6: reset in WAIT
    set_req(0, 1'b0, 32'h40800000, 32'h0);
    tick();
    req_valid = '0;
    for (int i = 0; i < 6; i++) tick();
    rst = 1'b1;
    tick();
    chk("t6_outputs", {u_start, u_op, u_rm, rsp_valid, rsp_id, err}, 0);
    chk("t6_u_a", u_a, 0);
    chk("t6_rsp_data", rsp_data, 0);
    rst = 1'b0;
    req_valid = 2'b11;
    #1 chk("t6_idle_rr0", req_ready, 2'b01);
    req_valid = '0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
